// File: rtl/tt_io_pkg.sv
// Shared types and constants for the two-bank IO controller.
//   io_mode_e    : per-bank drive mode (GND, STATIC, COUNT, WALK)
//   cfg_state_e  : configuration-port sequencing for deferred MODE writes
//   ADDR_*       : register select codes on cfg_addr
//   MODE_*_LSB   : bit offsets of each bank's field in the MODE register
package tt_io_pkg;

    typedef enum logic [1:0] {
        MODE_GND    = 2'd0,
        MODE_STATIC = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_WALK   = 2'd3
    } io_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PEND  = 2'd1,
        ST_DRAIN = 2'd2
    } cfg_state_e;

    localparam logic [1:0] ADDR_MODE  = 2'd0;
    localparam logic [1:0] ADDR_VAL_A = 2'd1;
    localparam logic [1:0] ADDR_VAL_B = 2'd2;
    localparam logic [1:0] ADDR_OE_B  = 2'd3;

    localparam int unsigned MODE_A_LSB = 0;
    localparam int unsigned MODE_B_LSB = 2;
    localparam int unsigned MODE_BITS  = 4;

endpackage

// File: rtl/tt_io_bank_ctrl_if.sv
// Configuration write port (valid/ready) of tt_io_bank_ctrl.
//   cfg_valid : write/read request          (master -> slave)
//   cfg_addr  : register select             (master -> slave)
//   cfg_data  : write data                  (master -> slave)
//   cfg_ready : request accepted when high  (slave -> master)
interface tt_io_bank_ctrl_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_addr;
    logic [WIDTH-1:0] cfg_data;

    modport master (output cfg_valid, output cfg_addr, output cfg_data, input cfg_ready);
    modport slave  (input cfg_valid, input cfg_addr, input cfg_data, output cfg_ready);
endinterface

// File: rtl/tt_io_prescaler.sv
// Tick prescaler: counts 0..TICK_DIV-1 and wraps; tick is high while the
// count sits at TICK_DIV-1 (every cycle when TICK_DIV = 1, after reset).
//   clk, rst : clock, synchronous active-high reset
//   tick     : registered one-cycle pulse
module tt_io_prescaler #(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;

    // Next count with wrap at LAST.
    always_comb begin
        cnt_nxt = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
            cnt_nxt = '0;
        end
    end

    // tick is registered from the next count so it aligns with count == LAST.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tick  <= 1'b0;
        end else begin
            cnt_q <= cnt_nxt;
            tick  <= (cnt_nxt == LAST);
        end
    end
endmodule

// File: rtl/tt_io_bank_ctrl.sv
// Two-bank register-programmed output controller for a Tiny Tapeout tile.
// Bank A drives out_bus, bank B drives io_out with enables io_oe. Each bank
// runs GND / STATIC / COUNT / WALK, stepped by the prescaler tick. MODE
// writes are held pending and applied at the next tick; cfg_ready stays low
// from the cycle after acceptance through the cycle after that tick.
//   clk, rst  : clock, synchronous active-high reset
//   cfg       : configuration port (slave modport)
//   out_bus   : bank A output
//   io_out    : bank B output value
//   io_oe     : bank B output enable (1 = output)
//   tick      : prescaler pulse
//   rd_data   : register readback, only when IO_READBACK_EN is defined
module tt_io_bank_ctrl
    import tt_io_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned TICK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    tt_io_bank_ctrl_if.slave   cfg,
    output logic [WIDTH-1:0]   out_bus,
    output logic [WIDTH-1:0]   io_out,
    output logic [WIDTH-1:0]   io_oe,
    output logic               tick
`ifdef IO_READBACK_EN
    ,
    output logic [WIDTH-1:0]   rd_data
`endif
);
    cfg_state_e           state_q;
    logic                 ready_q;
    logic [MODE_BITS-1:0] pend_q;
    logic [WIDTH-1:0]     oe_q;
    logic                 accept;
    logic                 apply;

    tt_io_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign accept        = cfg.cfg_valid && ready_q;
    // A MODE accepted during a tick cycle is not yet in ST_PEND, so it waits a full period.
    assign apply         = (state_q == ST_PEND) && tick;
    assign cfg.cfg_ready = ready_q;

    // Deferred MODE sequencing and the OE_B register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ready_q <= 1'b1;
            pend_q  <= '0;
            oe_q    <= '0;
        end else begin
            if (accept && (cfg.cfg_addr == ADDR_OE_B)) begin
                oe_q <= cfg.cfg_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept && (cfg.cfg_addr == ADDR_MODE)) begin
                        pend_q  <= cfg.cfg_data[MODE_BITS-1:0];
                        state_q <= ST_PEND;
                        ready_q <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (tick) begin
                        state_q <= ST_DRAIN;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Per-bank VAL register, active mode and output drive.
    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam int unsigned LSB = (b == 0) ? MODE_A_LSB : MODE_B_LSB;
        localparam logic [1:0]  VAL_ADDR = (b == 0) ? ADDR_VAL_A : ADDR_VAL_B;

        io_mode_e         mode_q;
        io_mode_e         new_mode;
        logic [WIDTH-1:0] val_q;
        logic [WIDTH-1:0] out_q;
        logic             wr_val;

        assign wr_val   = accept && (cfg.cfg_addr == VAL_ADDR);
        assign new_mode = io_mode_e'(pend_q[LSB +: 2]);

        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q <= MODE_GND;
                val_q  <= '0;
                out_q  <= '0;
            end else begin
                if (wr_val) begin
                    val_q <= cfg.cfg_data;
                end
                if (apply) begin
                    // Mode entry (re)loads VAL; no VAL write can land here since ready is low.
                    mode_q <= new_mode;
                    case (new_mode)
                        MODE_GND:    out_q <= '0;
                        MODE_STATIC: out_q <= val_q;
                        MODE_COUNT:  out_q <= val_q;
                        default:     out_q <= (val_q == '0) ? WIDTH'(1) : val_q;
                    endcase
                end else begin
                    case (mode_q)
                        MODE_GND:    out_q <= '0;
                        MODE_STATIC: out_q <= wr_val ? cfg.cfg_data : val_q;
                        MODE_COUNT:  if (tick) out_q <= out_q + WIDTH'(1);
                        default:     if (tick) out_q <= {out_q[WIDTH-2:0], out_q[WIDTH-1]};
                    endcase
                end
            end
        end
    end

    assign out_bus = g_bank[0].out_q;
    assign io_out  = g_bank[1].out_q;
    assign io_oe   = oe_q;

`ifdef IO_READBACK_EN
    logic [WIDTH-1:0] rd_q;

    // Reads are serviced only while the port is busy (valid high, ready low).
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
        end else if (cfg.cfg_valid && !ready_q) begin
            case (cfg.cfg_addr)
                ADDR_MODE:  rd_q <= WIDTH'({g_bank[1].mode_q, g_bank[0].mode_q});
                ADDR_VAL_A: rd_q <= g_bank[0].val_q;
                ADDR_VAL_B: rd_q <= g_bank[1].val_q;
                default:    rd_q <= oe_q;
            endcase
        end
    end

    assign rd_data = rd_q;
`endif
endmodule

// File: tb/tb_tt_io_bank_ctrl.sv
// Self-checking bench for tt_io_bank_ctrl (WIDTH = 8, TICK_DIV = 4).
module tb_tt_io_bank_ctrl;
    localparam int unsigned W  = 8;
    localparam int unsigned TD = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tt_io_bank_ctrl_if #(.WIDTH(W)) cfg_if ();
    logic [W-1:0] out_bus, io_out, io_oe;
    logic         tick;
`ifdef IO_READBACK_EN
    logic [W-1:0] rd_data;
`endif

    tt_io_bank_ctrl #(.WIDTH(W), .TICK_DIV(TD)) dut (
        .clk     (clk),
        .rst     (rst),
        .cfg     (cfg_if),
        .out_bus (out_bus),
        .io_out  (io_out),
        .io_oe   (io_oe),
        .tick    (tick)
`ifdef IO_READBACK_EN
        ,
        .rd_data (rd_data)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference state: what each register/output holds in the current cycle.
    int m_cnt, m_pval, m_oe, m_rd;
    bit m_pend, m_release, m_ready;
    int m_mode [2];
    int m_val  [2];
    int m_out  [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int entry_val(input int mode, input int val);
        case (mode)
            0:       return 0;
            3:       return (val == 0) ? 1 : val;
            default: return val;
        endcase
    endfunction

    function automatic int step_val(input int mode, input int cur, input int val, input bit tk);
        case (mode)
            0:       return 0;
            1:       return val;
            2:       return tk ? (cur + 1) % 256 : cur;
            default: return tk ? (cur * 2) % 256 + cur / 128 : cur;
        endcase
    endfunction

    function automatic int reg_read(input int a);
        case (a)
            0:       return m_mode[0] + 4 * m_mode[1];
            1:       return m_val[0];
            2:       return m_val[1];
            default: return m_oe;
        endcase
    endfunction

    task automatic model_update();
        bit tk, acc, apply;
        int a, d;
        int nval [2];
        if (rst) begin
            m_cnt = 0; m_pval = 0; m_oe = 0; m_rd = 0;
            m_pend = 0; m_release = 0; m_ready = 1;
            for (int b = 0; b < 2; b++) begin
                m_mode[b] = 0; m_val[b] = 0; m_out[b] = 0;
            end
            return;
        end
        tk  = (m_cnt == TD - 1);
        acc = cfg_if.cfg_valid && m_ready;
        a   = int'(cfg_if.cfg_addr);
        d   = int'(cfg_if.cfg_data);
        if (cfg_if.cfg_valid && !m_ready) m_rd = reg_read(a);
        apply   = m_pend && tk;
        nval[0] = (acc && a == 1) ? d : m_val[0];
        nval[1] = (acc && a == 2) ? d : m_val[1];
        for (int b = 0; b < 2; b++) begin
            if (apply) begin
                m_mode[b] = (m_pval >> (2 * b)) & 3;
                m_out[b]  = entry_val(m_mode[b], m_val[b]);
            end else begin
                m_out[b]  = step_val(m_mode[b], m_out[b], nval[b], tk);
            end
            m_val[b] = nval[b];
        end
        if (acc && a == 3) m_oe = d;
        m_release = apply;
        if (apply) m_pend = 0;
        if (acc && a == 0) begin
            m_pend = 1;
            m_pval = d & 15;
        end
        m_ready = !(m_pend || m_release);
        m_cnt   = (m_cnt + 1) % TD;
    endtask

    task automatic check_outputs();
        check_eq("out_bus", 32'(out_bus), 32'(m_out[0]));
        check_eq("io_out", 32'(io_out), 32'(m_out[1]));
        check_eq("io_oe", 32'(io_oe), 32'(m_oe));
        check_eq("tick", 32'(tick), 32'(m_cnt == TD - 1));
        check_eq("cfg_ready", 32'(cfg_if.cfg_ready), 32'(m_ready));
`ifdef IO_READBACK_EN
        check_eq("rd_data", 32'(rd_data), 32'(m_rd));
`endif
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
        bit done = 0;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = a;
        cfg_if.cfg_data  = d;
        for (int i = 0; i < 20 && !done; i++) begin
            done = cfg_if.cfg_ready;
            cycle();
        end
        cfg_if.cfg_valid = 1'b0;
        check_eq("write_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_ready();
        for (int i = 0; i < 40 && !cfg_if.cfg_ready; i++) cycle();
        check_eq("ready_wait", 32'(cfg_if.cfg_ready), 32'd1);
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 20 && !tick; i++) cycle();
        check_eq("tick_wait", 32'(tick), 32'd1);
    endtask

    initial begin
        int n, exp;
        rst = 1'b1;
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_addr  = 2'd0;
        cfg_if.cfg_data  = '0;
        cycle();
        cycle();
        rst = 1'b0;

        // Reset values.
        check_eq("rst_out_bus", 32'(out_bus), 32'h0);
        check_eq("rst_io_oe", 32'(io_oe), 32'h0);
        check_eq("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        for (int i = 0; i < 20; i++) cycle();
        check_eq("idle_out_bus", 32'(out_bus), 32'h0);

        // Static drive and live VAL update.
        cfg_write(2'd1, 8'hA5);
        cfg_write(2'd0, 8'h01);
        wait_ready();
        check_eq("static_a5", 32'(out_bus), 32'hA5);
        cfg_write(2'd1, 8'h3C);
        check_eq("static_3c", 32'(out_bus), 32'h3C);

        // Counter wrap.
        cfg_write(2'd1, 8'hFE);
        cfg_write(2'd0, 8'h02);
        wait_ready();
        check_eq("count_fe", 32'(out_bus), 32'hFE);
        wait_tick(); cycle();
        check_eq("count_ff", 32'(out_bus), 32'hFF);
        wait_tick(); cycle();
        check_eq("count_00", 32'(out_bus), 32'h00);

        // Walk from zero on bank B.
        cfg_write(2'd2, 8'h00);
        cfg_write(2'd3, 8'hFF);
        check_eq("oe_ff", 32'(io_oe), 32'hFF);
        cfg_write(2'd0, 8'h0C);
        wait_ready();
        check_eq("walk_01", 32'(io_out), 32'h01);
        for (int i = 0; i < 8; i++) begin
            wait_tick(); cycle();
            exp = 1 << ((i + 1) % 8);
            check_eq("walk_step", 32'(io_out), 32'(exp));
        end

        // Deferred MODE accepted in a tick cycle; VAL_A attempt blocked.
        wait_tick();
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = 2'd0;
        cfg_if.cfg_data  = 8'h01;
        cycle();
        cfg_if.cfg_addr  = 2'd1;
        cfg_if.cfg_data  = 8'h77;
        n = 0;
        while (!cfg_if.cfg_ready && n < 20) begin
            n++;
            cycle();
        end
        cfg_if.cfg_valid = 1'b0;
        check_eq("busy_cycles", 32'(n), 32'd5);
        check_eq("val_blocked", 32'(out_bus), 32'hFE);
        check_eq("b_gnd", 32'(io_out), 32'h00);

`ifdef IO_READBACK_EN
        cfg_write(2'd1, 8'h5A);
        cfg_write(2'd0, 8'h01);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_addr  = 2'd1;
        cycle();
        cfg_if.cfg_valid = 1'b0;
        check_eq("readback_val_a", 32'(rd_data), 32'h5A);
        wait_ready();
`endif

        // Reset mid-COUNT with a MODE write pending.
        cfg_write(2'd0, 8'h02);
        wait_ready();
        wait_tick(); cycle();
        wait_tick(); cycle();
        cfg_write(2'd0, 8'h0F);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check_eq("mid_rst_out_bus", 32'(out_bus), 32'h0);
        check_eq("mid_rst_io_oe", 32'(io_oe), 32'h0);
        check_eq("mid_rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        n = 1;
        while (!tick && n < 20) begin
            n++;
            cycle();
        end
        check_eq("first_tick", 32'(n), 32'd4);
        cycle();
        wait_tick(); cycle();
        check_eq("pend_dropped", 32'(out_bus), 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            rst              = ($urandom_range(0, 99) == 0);
            cfg_if.cfg_valid = 1'($urandom_range(0, 1));
            cfg_if.cfg_addr  = 2'($urandom_range(0, 3));
            cfg_if.cfg_data  = 8'($urandom_range(0, 255));
            cycle();
        end
        rst = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
